// File: rtl/seg7_pkg.sv
// Segment bit positions and active-low glyph patterns shared by the 7-segment encoder and decoder.
package seg7_pkg;

    localparam int SEG_T  = 0;
    localparam int SEG_RT = 1;
    localparam int SEG_RB = 2;
    localparam int SEG_B  = 3;
    localparam int SEG_LB = 4;
    localparam int SEG_LT = 5;
    localparam int SEG_M  = 6;

    // Arguments are "segment lit"; the bus drives a lit segment low.
    function automatic logic [6:0] seg_on(input logic t, input logic rt, input logic rb,
                                          input logic b, input logic lb, input logic lt,
                                          input logic m);
        logic [6:0] r;
        r         = '1;
        r[SEG_T]  = ~t;
        r[SEG_RT] = ~rt;
        r[SEG_RB] = ~rb;
        r[SEG_B]  = ~b;
        r[SEG_LB] = ~lb;
        r[SEG_LT] = ~lt;
        r[SEG_M]  = ~m;
        return r;
    endfunction

    localparam logic [6:0] SEG_PAT_0 = seg_on(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [6:0] SEG_PAT_1 = seg_on(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam logic [6:0] SEG_PAT_2 = seg_on(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    localparam logic [6:0] SEG_PAT_3 = seg_on(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    localparam logic [6:0] SEG_PAT_4 = seg_on(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_5 = seg_on(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_6 = seg_on(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_7 = seg_on(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam logic [6:0] SEG_PAT_8 = seg_on(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_9 = seg_on(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_A = seg_on(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_B = seg_on(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_C = seg_on(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam logic [6:0] SEG_PAT_D = seg_on(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    localparam logic [6:0] SEG_PAT_E = seg_on(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam logic [6:0] SEG_PAT_F = seg_on(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex encoder: 7-bit active-low pattern -> {legal, nibble}.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        legal_o  = 1'b1;
        nibble_o = 4'h0;
        case (seg_i)
            SEG_PAT_0: nibble_o = 4'h0;
            SEG_PAT_1: nibble_o = 4'h1;
            SEG_PAT_2: nibble_o = 4'h2;
            SEG_PAT_3: nibble_o = 4'h3;
            SEG_PAT_4: nibble_o = 4'h4;
            SEG_PAT_5: nibble_o = 4'h5;
            SEG_PAT_6: nibble_o = 4'h6;
            SEG_PAT_7: nibble_o = 4'h7;
            SEG_PAT_8: nibble_o = 4'h8;
            SEG_PAT_9: nibble_o = 4'h9;
            SEG_PAT_A: nibble_o = 4'hA;
            SEG_PAT_B: nibble_o = 4'hB;
            SEG_PAT_C: nibble_o = 4'hC;
            SEG_PAT_D: nibble_o = 4'hD;
            SEG_PAT_E: nibble_o = 4'hE;
            SEG_PAT_F: nibble_o = 4'hF;
            SEG_BLANK: legal_o  = 1'b0;
            default:   legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment display and recovers the hex digit in each position.
// Optional SEG7_DP_CAPTURE_EN adds decimal-point capture (iSEG_DP in, oDP out).
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [6:0]              iSEG,
    input  logic [NUM_DIGITS-1:0]   iSEL,
`ifdef SEG7_DP_CAPTURE_EN
    input  logic                    iSEG_DP,
    output logic [NUM_DIGITS-1:0]   oDP,
`endif
    output logic [4*NUM_DIGITS-1:0] oDIGITS,
    output logic [NUM_DIGITS-1:0]   oVALID_MASK,
    output logic                    oFRAME,
    output logic                    oERR
);

`ifdef SEG7_DP_CAPTURE_EN
    localparam int SW = NUM_DIGITS + 8;
`else
    localparam int SW = NUM_DIGITS + 7;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

    logic [SW-1:0]                 raw, s1_q, s2_q, prev_q;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]    digits_q, digits_d;
    logic [NUM_DIGITS-1:0]         valid_q, valid_d, seen_q, seen_d;
    logic                          frame_q, frame_d, err_q, err_d;
    logic [NUM_DIGITS-1:0]         sel_s2;
    logic [6:0]                    seg_s2;
    logic                          stable, sel_onehot, commit, pat_legal;
    logic [3:0]                    pat_nib;

`ifdef SEG7_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0]         dp_q, dp_d;
    logic                          s2_dp;
    assign raw   = {iSEG_DP, iSEL, iSEG};
    assign s2_dp = s2_q[SW-1];
    assign oDP   = dp_q;
`else
    assign raw   = {iSEL, iSEG};
`endif

    assign seg_s2     = s2_q[6:0];
    assign sel_s2     = s2_q[7 +: NUM_DIGITS];
    assign stable     = (s2_q == prev_q);
    assign sel_onehot = (|sel_s2) && ((sel_s2 & (sel_s2 - NUM_DIGITS'(1))) == '0);
    // Fires only on the count-up into saturation, so one commit per stable window.
    assign commit     = stable && (cnt_q == CNT_COMMIT) && sel_onehot;

    seg7_pattern_decode u_dec (
        .seg_i    (seg_s2),
        .legal_o  (pat_legal),
        .nibble_o (pat_nib)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (!stable)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        err_d    = 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
        dp_d     = dp_q;
`endif
        if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_s2[i]) begin
                    if (pat_legal) begin
                        digits_d[i] = pat_nib;
                        valid_d[i]  = 1'b1;
                    end else begin
                        valid_d[i]  = 1'b0;
                        err_d       = 1'b1;
                    end
`ifdef SEG7_DP_CAPTURE_EN
                    dp_d[i] = ~s2_dp;
`endif
                end
            end
            if ((seen_q | sel_s2) == '1) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_q | sel_s2;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
            dp_q     <= '0;
`endif
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
`ifdef SEG7_DP_CAPTURE_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign oDIGITS     = digits_q;
    assign oVALID_MASK = valid_q;
    assign oFRAME      = frame_q;
    assign oERR        = err_q;

endmodule
